wb_arbiter: RTL

- Writeback stage directly downstream of the execution pipes (pipe_0/1/2).
- Captures one result per pipe per cycle into per-pipe result FIFOs.
- Arbitrates FIFO heads onto a smaller set of registered register-file/ROB writeback ports using round-robin priority.
- Back-pressures issue through per-pipe busy flags, because pipes cannot stall mid-flight.

---
 rtl/wb_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: per-pipe result FIFOs, round-robin onto registered PRF/ROB ports
module wb_arbiter #(
    parameter int NUM_PIPES    = 3,
    parameter int NUM_WB_PORTS = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int SKID         = 2,
    parameter int PRF_IDX_W    = 6,
    parameter int ROB_IDX_W    = 5
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [NUM_PIPES-1:0]              res_valid,
    input  logic [NUM_PIPES-1:0]              res_rf_en,
    input  logic [NUM_PIPES*PRF_IDX_W-1:0]    res_prf_idx,
    input  logic [NUM_PIPES*ROB_IDX_W-1:0]    res_rob_idx,
    input  logic [NUM_PIPES*32-1:0]           res_data,
    output logic [NUM_PIPES-1:0]              pipe_busy,
    output logic [NUM_WB_PORTS-1:0]           wb_valid,
    output logic [NUM_WB_PORTS-1:0]           wb_rf_en,
    output logic [NUM_WB_PORTS*PRF_IDX_W-1:0] wb_prf_idx,
    output logic [NUM_WB_PORTS*ROB_IDX_W-1:0] wb_rob_idx,
    output logic [NUM_WB_PORTS*32-1:0]        wb_data,
    output logic                              overflow_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    // Entry layout: {rf_en, prf_idx, rob_idx, data}
    localparam int ENT_W = 1 + PRF_IDX_W + ROB_IDX_W + 32;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BUSY_TH = CNT_W'(FIFO_DEPTH - SKID);

    logic [ENT_W-1:0]        r_mem [NUM_PIPES][FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr [NUM_PIPES];
    logic [PTR_W-1:0]        r_rd_ptr [NUM_PIPES];
    logic [CNT_W-1:0]        r_count [NUM_PIPES];
    logic [RR_W-1:0]         r_rr_ptr;
    logic [NUM_PIPES-1:0]    r_busy;
    logic                    r_overflow;

    logic [NUM_WB_PORTS-1:0]           r_wb_valid;
    logic [NUM_WB_PORTS-1:0]           r_wb_rf_en;
    logic [NUM_WB_PORTS*PRF_IDX_W-1:0] r_wb_prf_idx;
    logic [NUM_WB_PORTS*ROB_IDX_W-1:0] r_wb_rob_idx;
    logic [NUM_WB_PORTS*32-1:0]        r_wb_data;

    logic [ENT_W-1:0]        w_push_ent [NUM_PIPES];
    logic [ENT_W-1:0]        w_head [NUM_PIPES];
    logic [NUM_PIPES-1:0]    w_push;
    logic [NUM_PIPES-1:0]    w_push_ok;
    logic [NUM_PIPES-1:0]    w_drop;
    logic [NUM_PIPES-1:0]    w_grant;
    logic [CNT_W-1:0]        w_count_next [NUM_PIPES];
    logic [NUM_WB_PORTS-1:0] w_port_vld;
    logic [RR_W-1:0]         w_port_src [NUM_WB_PORTS];
    logic [ENT_W-1:0]        w_port_ent [NUM_WB_PORTS];
    logic [RR_W-1:0]         w_rr_next;

    // Pack incoming results and expose each FIFO head
    always_comb begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            w_push_ent[i] = {res_rf_en[i],
                             res_prf_idx[i*PRF_IDX_W +: PRF_IDX_W],
                             res_rob_idx[i*ROB_IDX_W +: ROB_IDX_W],
                             res_data[i*32 +: 32]};
            w_head[i]     = r_mem[i][r_rd_ptr[i]];
        end
    end

    // Round-robin scan from rr_ptr: first NUM_WB_PORTS non-empty FIFOs win, k-th winner to port k
    always_comb begin
        int n;
        int idx;
        w_grant    = '0;
        w_port_vld = '0;
        w_rr_next  = r_rr_ptr;
        for (int k = 0; k < NUM_WB_PORTS; k++) begin
            w_port_src[k] = '0;
        end
        n = 0;
        for (int j = 0; j < NUM_PIPES; j++) begin
            idx = int'(r_rr_ptr) + j;
            if (idx >= NUM_PIPES) begin
                idx = idx - NUM_PIPES;
            end
            if ((r_count[idx] != '0) && (n < NUM_WB_PORTS)) begin
                w_grant[idx]  = 1'b1;
                w_port_vld[n] = 1'b1;
                w_port_src[n] = RR_W'(idx);
                w_rr_next     = (idx == NUM_PIPES - 1) ? '0 : RR_W'(idx + 1);
                n             = n + 1;
            end
        end
        for (int k = 0; k < NUM_WB_PORTS; k++) begin
            w_port_ent[k] = w_head[w_port_src[k]];
        end
    end

    // Push acceptance (a full FIFO still accepts when popped this cycle) and next occupancy
    always_comb begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            w_push[i]       = res_valid[i] & ~flush;
            w_push_ok[i]    = w_push[i] & ((r_count[i] != FULL) | w_grant[i]);
            w_drop[i]       = w_push[i] & (r_count[i] == FULL) & ~w_grant[i];
            w_count_next[i] = flush ? '0
                            : r_count[i] + CNT_W'(w_push_ok[i]) - CNT_W'(w_grant[i]);
        end
    end

    // FIFO storage; contents are don't-care until a pointer covers them
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (w_push_ok[i]) begin
                r_mem[i][r_wr_ptr[i]] <= w_push_ent[i];
            end
        end
    end

    // FIFO pointers, counts, busy flags, rr pointer and sticky overflow
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_busy     <= '0;
            r_rr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_count[i] <= w_count_next[i];
                r_busy[i]  <= (w_count_next[i] >= BUSY_TH);
                if (flush) begin
                    r_wr_ptr[i] <= '0;
                    r_rd_ptr[i] <= '0;
                end else begin
                    if (w_push_ok[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                    if (w_grant[i])   r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                end
            end
            r_rr_ptr <= flush ? '0 : w_rr_next;
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Writeback registers; ungranted ports drop valid but hold their fields
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wb_valid   <= '0;
            r_wb_rf_en   <= '0;
            r_wb_prf_idx <= '0;
            r_wb_rob_idx <= '0;
            r_wb_data    <= '0;
        end else begin
            for (int k = 0; k < NUM_WB_PORTS; k++) begin
                if (w_port_vld[k] && !flush) begin
                    r_wb_valid[k]                         <= 1'b1;
                    r_wb_rf_en[k]                         <= w_port_ent[k][ENT_W-1];
                    r_wb_prf_idx[k*PRF_IDX_W +: PRF_IDX_W] <= w_port_ent[k][32+ROB_IDX_W +: PRF_IDX_W];
                    r_wb_rob_idx[k*ROB_IDX_W +: ROB_IDX_W] <= w_port_ent[k][32 +: ROB_IDX_W];
                    r_wb_data[k*32 +: 32]                 <= w_port_ent[k][31:0];
                end else begin
                    r_wb_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign pipe_busy    = r_busy;
    assign overflow_err = r_overflow;
    assign wb_valid     = r_wb_valid;
    assign wb_rf_en     = r_wb_rf_en;
    assign wb_prf_idx   = r_wb_prf_idx;
    assign wb_rob_idx   = r_wb_rob_idx;
    assign wb_data      = r_wb_data;

endmodule
